// File: rtl/seq_div_pkg.sv
// Shared types and default widths for the restoring sequential divider.
// Any consumer imports this with seq_div_pkg::*.
package seq_div_pkg;

  localparam int SEQ_DIV_N_W = 16;
  localparam int SEQ_DIV_D_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and emit the quotient bit.
module seq_div_step #(
  parameter int D_W = 8
) (
  input  logic [D_W:0]   i_rem,
  input  logic           i_msb,
  input  logic [D_W-1:0] i_divisor,
  output logic [D_W:0]   o_rem,
  output logic           o_qbit
);

  logic [D_W+1:0] w_shifted;
  logic [D_W:0]   w_diff;

  assign w_shifted = {i_rem, i_msb};
  assign o_qbit    = (w_shifted >= {2'b00, i_divisor});

  // The difference is only selected when it is below the divisor, so the
  // low D_W+1 bits are enough to hold it exactly.
  assign w_diff = w_shifted[D_W:0] - {1'b0, i_divisor};
  assign o_rem  = o_qbit ? w_diff : w_shifted[D_W:0];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock.
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one shift/compare/subtract iteration per edge, N_W in total
// DONE  | Q/R/dbz valid, done high for this single cycle
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int N_W = SEQ_DIV_N_W,
  parameter int D_W = SEQ_DIV_D_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] A,
  input  logic [D_W-1:0] B,
  output logic [N_W-1:0] Q,
  output logic [D_W-1:0] R,
  output logic           busy,
  output logic           done,
  output logic           dbz
);

  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_W-1:0]   r_dvd;
  logic [D_W:0]     r_rem;
  logic [D_W-1:0]   r_dsr;
  logic [CNT_W-1:0] r_cnt;
  logic [N_W-1:0]   r_q;
  logic [D_W-1:0]   r_r;
  logic             r_dbz;

  logic [D_W:0]     w_rem_nxt;
  logic             w_qbit;
  logic [N_W-1:0]   w_dvd_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_b_zero;

  seq_div_step #(
    .D_W(D_W)
  ) u_step (
    .i_rem     (r_rem),
    .i_msb     (r_dvd[N_W-1]),
    .i_divisor (r_dsr),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  // Quotient bits enter from the right as dividend bits leave on the left.
  assign w_dvd_nxt = {r_dvd[N_W-2:0], w_qbit};
  assign w_b_zero  = (B == '0);
  assign w_accept  = (r_state == IDLE) && start;
  assign w_last    = (r_state == RUN) && (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_b_zero ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd <= '0;
      r_rem <= '0;
      r_dsr <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= A;
      r_dsr <= B;
      r_rem <= '0;
      r_cnt <= CNT_W'(N_W - 1);
      // Divide-by-zero skips RUN entirely, so its result is published here.
      if (w_b_zero) begin
        r_q   <= '1;
        r_r   <= '0;
        r_dbz <= 1'b1;
      end else begin
        r_dbz <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_dvd <= w_dvd_nxt;
      r_rem <= w_rem_nxt;
      if (w_last) begin
        r_q <= w_dvd_nxt;
        r_r <= w_rem_nxt[D_W-1:0];
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign Q   = r_q;
  assign R   = r_r;
  assign dbz = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, ignored starts,
// mid-run reset and randomized operands against an arithmetic model.
module tb_seq_divider;

  localparam int N_W = 16;
  localparam int D_W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N_W-1:0] A;
  logic [D_W-1:0] B;
  logic [N_W-1:0] Q;
  logic [D_W-1:0] R;
  logic           busy;
  logic           done;
  logic           dbz;

  int n_tests = 0;
  int n_fail  = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_count++;

  seq_divider #(
    .N_W(N_W),
    .D_W(D_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  // Waits for IDLE, presents operands and returns #1 after the accepting edge;
  // operands are then scrambled to show the DUT no longer looks at them.
  task automatic launch(input logic [N_W-1:0] a, input logic [D_W-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy === 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = N_W'($urandom);
    B = D_W'($urandom);
  endtask

  // Edges after the current point until done is seen; -1 if it never comes.
  task automatic wait_done(output int lat);
    lat = -1;
    if (done === 1'b1) begin
      lat = 0;
    end else begin
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
          lat = k;
          break;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    n_tests++;
    if ({Q, R, busy, done, dbz} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: Q=%0d R=%0d busy=%b done=%b dbz=%b, want all zero",
               Q, R, busy, done, dbz);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    int va [5] = '{1000, 'hFFFF, 5, 'h1234, 10};
    int vb [5] = '{7, 'hFF, 9, 0, 3};
    int vq [5] = '{142, 257, 0, 'hFFFF, 3};
    int vr [5] = '{6, 0, 5, 0, 1};
    int vz [5] = '{0, 0, 0, 1, 0};
    int lat;
    int exp_lat;
    logic [N_W-1:0] q_hold;
    logic [D_W-1:0] r_hold;
    for (int i = 0; i < 5; i++) begin
      exp_lat = (vb[i] == 0) ? 0 : N_W;
      launch(N_W'(va[i]), D_W'(vb[i]));
      wait_done(lat);
      n_tests++;
      if (lat != exp_lat) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, exp_lat);
      end
      n_tests++;
      if (Q !== N_W'(vq[i]) || R !== D_W'(vr[i]) || dbz !== vz[i][0]) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: Q=%0d R=%0d dbz=%b, want Q=%0d R=%0d dbz=%0d",
                 i, Q, R, dbz, vq[i], vr[i], vz[i]);
      end
      q_hold = Q;
      r_hold = R;
      @(posedge clk);
      #1;
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_done_pulse[%0d]: done=%b busy=%b a cycle later, want 0 0",
                 i, done, busy);
      end
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (Q !== q_hold || R !== r_hold || dbz !== vz[i][0]) begin
        n_fail++;
        $display("FAIL directed_hold[%0d]: Q=%0d R=%0d dbz=%b, want Q=%0d R=%0d dbz=%0d",
                 i, Q, R, dbz, q_hold, r_hold, vz[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    int c0;
    c0 = done_count;
    launch(16'd50000, 8'd201);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    A = 16'd777;
    B = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    n_tests++;
    if (lat + 5 != N_W) begin
      n_fail++;
      $display("FAIL ignored_start_latency: got %0d edges, want %0d", lat + 5, N_W);
    end
    n_tests++;
    if (Q !== 16'(50000 / 201) || R !== 8'(50000 % 201)) begin
      n_fail++;
      $display("FAIL ignored_start_result: Q=%0d R=%0d, want Q=%0d R=%0d",
               Q, R, 50000 / 201, 50000 % 201);
    end
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (done_count - c0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start_single_done: done pulses=%0d busy=%b, want 1 0",
               done_count - c0, busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    int c0;
    launch(16'd54321, 8'd77);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    c0 = done_count;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({Q, R, busy, done, dbz} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset_outputs: Q=%0d R=%0d busy=%b done=%b dbz=%b, want all zero",
               Q, R, busy, done, dbz);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    A = 16'd40000;
    B = 8'd123;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = N_W'($urandom);
    B = D_W'($urandom);
    n_tests++;
    if (busy !== 1'b1 || done_count != c0) begin
      n_fail++;
      $display("FAIL midrun_reset_restart: busy=%b stray done=%0d, want 1 0",
               busy, done_count - c0);
    end
    wait_done(lat);
    n_tests++;
    if (lat != N_W || Q !== 16'(40000 / 123) || R !== 8'(40000 % 123) || dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_result: lat=%0d Q=%0d R=%0d dbz=%b, want lat=%0d Q=%0d R=%0d dbz=0",
               lat, Q, R, dbz, N_W, 40000 / 123, 40000 % 123);
    end
  endtask

  task automatic test_random;
    int lat;
    int a;
    int b;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(1, 255));
      launch(N_W'(a), D_W'(b));
      wait_done(lat);
      n_tests++;
      if (lat != N_W || Q !== N_W'(a / b) || R !== D_W'(a % b) || dbz !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d] %0d/%0d: lat=%0d Q=%0d R=%0d dbz=%b, want lat=%0d Q=%0d R=%0d dbz=0",
                 i, a, b, lat, Q, R, dbz, N_W, a / b, a % b);
      end
      n_tests++;
      if (int'(Q) * b + int'(R) != a || int'(R) >= b) begin
        n_fail++;
        $display("FAIL random_identity[%0d]: Q*B+R=%0d R=%0d, want A=%0d and R<%0d",
                 i, int'(Q) * b + int'(R), R, a, b);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    test_reset;
    test_directed;
    test_start_ignored;
    test_reset_mid_run;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter N_W, default 16, meaning dividend and quotient width.
REQ-002 The block SHALL have parameter D_W, default 8, meaning divisor and remainder width; D_W <= N_W.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, a request to divide, sampled only in IDLE.
REQ-006 The block SHALL have port A, input, N_W, the unsigned dividend, captured on start acceptance.
REQ-007 The block SHALL have port B, input, D_W, the unsigned divisor, captured on start acceptance.
REQ-008 The block SHALL have port Q, output, N_W, the registered quotient.
REQ-009 The block SHALL have port R, output, D_W, the registered remainder.
REQ-010 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse marking valid Q/R/dbz.
REQ-012 The block SHALL have port dbz, output, 1, the divide-by-zero flag, valid with done.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 The block SHALL accept start only in IDLE: on that edge it latches A into the dividend shift register, latches B, clears the partial remainder (D_W+1 bits), loads the iteration counter with N_W-1, and goes to RUN; if B==0 it goes directly to DONE.
REQ-015 The block SHALL, on each RUN edge, shift {rem, dividend} left by 1; if the shifted rem >= divisor, it subtracts the divisor and shifts in quotient bit 1, otherwise it shifts in 0 (restoring, one bit per cycle).
REQ-016 The block SHALL, on the RUN edge where counter==0, update Q/R from the final iteration and go to DONE; otherwise it decrements the counter.
REQ-017 The block SHALL present valid Q/R on the outputs exactly N_W clock edges after the accepting edge (16 by default), with done high for the following cycle only.
REQ-018 The block SHALL transition from DONE to IDLE on the next edge unconditionally.
REQ-019 The block SHALL ignore start in RUN and DONE, without queueing it.
REQ-020 The block SHALL hold Q, R and dbz stable from done until the next accepted start.
REQ-021 The block SHALL, for B==0, set Q = all ones, R = 0 and dbz = 1, with done asserted one cycle after acceptance.
REQ-022 The block SHALL clear dbz on any accepted start with nonzero B.
REQ-023 The block SHALL satisfy A == Q*B + R with R < B for every nonzero B; no overflow is possible.
REQ-024 The block SHALL ignore changes on A/B after acceptance.

Reset
REQ-025 The block SHALL, while rst is high, force state IDLE, Q=0, R=0, busy=0, done=0, dbz=0, counter=0, and clear internal registers, independent of clk.
REQ-026 The block SHALL, on reset mid-RUN, abort the operation with no done pulse; the first edge after rst deasserts SHALL be able to accept start.

Structure
REQ-027 The shared package seq_div_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default width constants.
REQ-028 The block SHALL have one combinational sub-module, seq_div_step, performing a compare/subtract/quotient-bit iteration; the top holds the FSM, counter and registers.

Verification
REQ-029 The bench SHALL apply A=1000, B=7 with start -> done after 16 cycles, Q=142, R=6, dbz=0.
REQ-030 The bench SHALL apply A=0xFFFF, B=0xFF -> Q=257, R=0; then A=5, B=9 -> Q=0, R=5.
REQ-031 The bench SHALL apply A=0x1234, B=0 -> done one cycle after accept, Q=0xFFFF, R=0, dbz=1; a following A=10, B=3 -> Q=3, R=1, dbz=0.
REQ-032 The bench SHALL pulse start again at cycle 5 of RUN with different A/B -> the result matches the first operands, with a single done.
REQ-033 The bench SHALL assert rst at cycle 8 of RUN -> outputs zero, busy=0, no done; a new start after release yields a correct result.
REQ-034 The bench SHALL run 1000 random nonzero-B operations -> A == Q*B + R and R < B every time.
